// File: rtl/life_sequencer.sv
// Generation controller for the nextstate array: owns the grid register, kicks the
// array via stateready, waits a fixed settle time and commits outgrid back.
module life_sequencer #(
   parameter int unsigned ROWS          = 48,
   parameter int unsigned COLS          = 80,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned GEN_W         = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   step,
   input  logic [7:0]             frames_per_gen,
   input  logic                   frame_tick,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [ROWS*COLS-1:0]   load_grid,
   output logic                   stateready,
   input  logic [ROWS*COLS-1:0]   next_grid,
   output logic [ROWS*COLS-1:0]   grid,
   output logic [GEN_W-1:0]       gen_count,
   output logic                   busy,
   output logic                   gen_done,
   output logic                   still
);

   localparam int unsigned CELLS = ROWS * COLS;
   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, KICK, SETTLE, COMMIT} state_e;

   state_e             state_q;
   logic [CELLS-1:0]   grid_q;
   logic [GEN_W-1:0]   gen_q;
   logic [SET_W-1:0]   settle_q;
   logic [7:0]         frame_q;
   logic [7:0]         frame_last;
   logic               pending_q;
   logic               sr_q;
   logic               done_q;
   logic               still_q;
   logic               busy_q;
   logic               ready_q;

   // frames_per_gen of 0 behaves as 1
   always_comb begin
      frame_last = 8'd0;
      if (frames_per_gen != 8'd0) frame_last = frames_per_gen - 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         grid_q    <= '0;
         gen_q     <= '0;
         settle_q  <= '0;
         frame_q   <= '0;
         pending_q <= 1'b0;
         sr_q      <= 1'b0;
         done_q    <= 1'b0;
         still_q   <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;

         // Frame pacing runs even while busy; a threshold only raises a single flag
         if (!run) begin
            frame_q   <= '0;
            pending_q <= 1'b0;
         end else if (frame_tick) begin
            if (frame_q == frame_last) begin
               frame_q   <= '0;
               pending_q <= 1'b1;
            end else begin
               frame_q <= frame_q + 8'd1;
            end
         end

         case (state_q)
            IDLE: begin
               if (load_valid) begin
                  grid_q    <= load_grid;
                  gen_q     <= '0;
                  still_q   <= 1'b0;
                  frame_q   <= '0;
                  pending_q <= 1'b0;
               end else if (pending_q || (step && !run)) begin
                  state_q <= KICK;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            KICK: begin
               sr_q     <= ~sr_q;
               settle_q <= SET_W'(SETTLE_CYCLES - 1);
               state_q  <= SETTLE;
            end
            SETTLE: begin
               if (settle_q == '0) state_q <= COMMIT;
               else                settle_q <= settle_q - SET_W'(1);
            end
            COMMIT: begin
               grid_q    <= next_grid;
               gen_q     <= gen_q + GEN_W'(1);
               still_q   <= (next_grid == grid_q);
               done_q    <= 1'b1;
               pending_q <= 1'b0;
               state_q   <= IDLE;
               busy_q    <= 1'b0;
               ready_q   <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grid       = grid_q;
   assign gen_count  = gen_q;
   assign stateready = sr_q;
   assign gen_done   = done_q;
   assign still      = still_q;
   assign busy       = busy_q;
   assign load_ready = ready_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: a torus Life model stands in for the nextstate array
// and serves as the reference for committed generations.
module tb_life_sequencer;

   localparam int ROWS = 48;
   localparam int COLS = 80;
   localparam int N    = ROWS * COLS;
   localparam int SR   = 4;
   localparam int SC   = 4;
   localparam int SN   = SR * SC;

   logic           clk = 1'b0;
   logic           reset, run, step, frame_tick, load_valid;
   logic [7:0]     frames_per_gen;
   logic           load_ready, stateready, busy, gen_done, still;
   logic [N-1:0]   load_grid, next_grid, grid;
   logic [15:0]    gen_count;

   logic           s_reset, s_step, s_load_valid, s_load_ready, s_stateready;
   logic           s_busy, s_gen_done, s_still;
   logic [SN-1:0]  s_load_grid, s_next_grid, s_grid;
   logic [2:0]     s_gen_count;
   logic [N-1:0]   s_life;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N-1:0] m_grid;
   int           m_gen;
   logic         m_still;
   logic         m_sr;

   always #5 clk = ~clk;

   life_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .frames_per_gen(frames_per_gen), .frame_tick(frame_tick),
      .load_valid(load_valid), .load_ready(load_ready), .load_grid(load_grid),
      .stateready(stateready), .next_grid(next_grid), .grid(grid),
      .gen_count(gen_count), .busy(busy), .gen_done(gen_done), .still(still)
   );

   life_sequencer #(.ROWS(SR), .COLS(SC), .SETTLE_CYCLES(1), .GEN_W(3)) dut_s (
      .clk(clk), .reset(s_reset), .run(1'b0), .step(s_step),
      .frames_per_gen(8'd0), .frame_tick(1'b0),
      .load_valid(s_load_valid), .load_ready(s_load_ready), .load_grid(s_load_grid),
      .stateready(s_stateready), .next_grid(s_next_grid), .grid(s_grid),
      .gen_count(s_gen_count), .busy(s_busy), .gen_done(s_gen_done), .still(s_still)
   );

   // B3/S23 on a torus of the given size
   function automatic logic [N-1:0] life(input logic [N-1:0] g, input int rows, input int cols);
      logic [N-1:0] res;
      int nb, rr, cc;
      res = '0;
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++) begin
            nb = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0) begin
                     rr = (r + dr + rows) % rows;
                     cc = (c + dc + cols) % cols;
                     nb += int'(g[rr*cols + cc]);
                  end
            res[r*cols + c] = (nb == 3) || (g[r*cols + c] && nb == 2);
         end
      return res;
   endfunction

   function automatic logic [N-1:0] set_cell(input logic [N-1:0] g, input int r, input int c);
      logic [N-1:0] res;
      res = g;
      res[((r + ROWS) % ROWS) * COLS + ((c + COLS) % COLS)] = 1'b1;
      return res;
   endfunction

   function automatic logic [N-1:0] glider_at(input int r0, input int c0);
      logic [N-1:0] g;
      g = '0;
      g = set_cell(g, r0,     c0 + 1);
      g = set_cell(g, r0 + 1, c0 + 2);
      g = set_cell(g, r0 + 2, c0);
      g = set_cell(g, r0 + 2, c0 + 1);
      g = set_cell(g, r0 + 2, c0 + 2);
      return g;
   endfunction

   function automatic logic [N-1:0] rand_grid();
      logic [N-1:0] g;
      for (int i = 0; i < N / 32; i++) g[i*32 +: 32] = $urandom & $urandom;
      return g;
   endfunction

   assign next_grid   = life(grid, ROWS, COLS);
   assign s_life      = life({{(N-SN){1'b0}}, s_grid}, SR, SC);
   assign s_next_grid = s_life[SN-1:0];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (gen_done) begin ok = 1'b1; return; end
      end
   endtask

   task automatic do_load(input logic [N-1:0] g, output bit ok);
      ok = 1'b0;
      load_grid  = g;
      load_valid = 1'b1;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (load_ready) ok = 1'b1;
         tick();
      end
      load_valid = 1'b0;
      if (ok) begin m_grid = g; m_gen = 0; m_still = 1'b0; end
   endtask

   task automatic do_step(output bit ok);
      step = 1'b1;
      tick();
      step = 1'b0;
      wait_done(20, ok);
      if (ok) begin
         m_still = (life(m_grid, ROWS, COLS) == m_grid);
         m_grid  = life(m_grid, ROWS, COLS);
         m_gen   = (m_gen + 1) % 65536;
         m_sr    = ~m_sr;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; s_reset = 1'b1;
      tick(); tick();
      reset = 1'b0; s_reset = 1'b0;
      m_grid = '0; m_gen = 0; m_still = 1'b0; m_sr = 1'b0;
      n_checks++;
      if (grid !== '0 || gen_count !== 16'd0 || stateready !== 1'b0 || gen_done !== 1'b0 ||
          still !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset: gc=%0d sr=%b done=%b still=%b busy=%b rdy=%b grid_nz=%b, need all 0 with rdy=1",
                  gen_count, stateready, gen_done, still, busy, load_ready, |grid);
      end
      n_checks++;
      if (s_grid !== '0 || s_gen_count !== 3'd0 || s_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_small: grid=%h gc=%0d busy=%b, need 0/0/0", s_grid, s_gen_count, s_busy);
      end
   endtask

   task automatic test_blinker();
      logic [N-1:0] h, v;
      logic sr0;
      int early;
      bit ok;
      h = '0; v = '0;
      for (int i = 0; i < 3; i++) begin
         h = set_cell(h, 10, 20 + i);
         v = set_cell(v, 9 + i, 21);
      end
      do_load(h, ok);
      sr0 = stateready;
      early = 0;
      step = 1'b1;
      tick();
      step = 1'b0;
      early += int'(gen_done);
      n_checks++;
      if (stateready !== sr0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL blinker_kick: sr=%b busy=%b, need sr=%b busy=1", stateready, busy, sr0);
      end
      tick();
      early += int'(gen_done);
      n_checks++;
      if (stateready !== ~sr0) begin
         n_fail++;
         $display("FAIL blinker_toggle: sr=%b, need %b", stateready, ~sr0);
      end
      tick(); early += int'(gen_done);
      tick(); early += int'(gen_done);
      tick();
      n_checks++;
      if (early != 0 || gen_done !== 1'b1) begin
         n_fail++;
         $display("FAIL blinker_latency: early=%0d done@5=%b, need 0 and 1", early, gen_done);
      end
      n_checks++;
      if (grid !== v || gen_count !== 16'd1 || still !== 1'b0 || stateready !== ~sr0) begin
         n_fail++;
         $display("FAIL blinker_result: vertical=%b gc=%0d still=%b sr=%b, need 1/1/0/%b",
                  grid === v, gen_count, still, stateready, ~sr0);
      end
      tick();
      n_checks++;
      if (gen_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL blinker_pulse: done=%b busy=%b, need 0/0", gen_done, busy);
      end
      m_grid = v; m_gen = 1; m_sr = ~sr0;
   endtask

   task automatic test_block();
      logic [N-1:0] b;
      bit ok;
      b = '0;
      b = set_cell(b, 5, 5); b = set_cell(b, 5, 6);
      b = set_cell(b, 6, 5); b = set_cell(b, 6, 6);
      do_load(b, ok);
      for (int k = 1; k <= 2; k++) begin
         do_step(ok);
         n_checks++;
         if (!ok || grid !== b || still !== 1'b1 || gen_count !== 16'(k)) begin
            n_fail++;
            $display("FAIL block_step%0d: done=%b same=%b still=%b gc=%0d, need 1/1/1/%0d",
                     k, ok, grid === b, still, gen_count, k);
         end
      end
   endtask

   task automatic test_run();
      int pulses, fc;
      bit ok, expect_gen;
      do_load(rand_grid(), ok);
      run = 1'b1;
      frames_per_gen = 8'd3;
      fc = 0;
      for (int k = 1; k <= 9; k++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         fc++;
         expect_gen = (fc == 3);
         if (fc == 3) fc = 0;
         pulses = int'(gen_done);
         for (int t = 0; t < 12; t++) begin tick(); pulses += int'(gen_done); end
         if (expect_gen) begin
            m_still = (life(m_grid, ROWS, COLS) == m_grid);
            m_grid = life(m_grid, ROWS, COLS); m_gen++; m_sr = ~m_sr;
         end
         n_checks++;
         if (pulses != int'(expect_gen) || grid !== m_grid || gen_count !== 16'(m_gen)) begin
            n_fail++;
            $display("FAIL run3_tick%0d: done_cycles=%0d grid_ok=%b gc=%0d, need %0d/1/%0d",
                     k, pulses, grid === m_grid, gen_count, expect_gen, m_gen);
         end
      end
      frames_per_gen = 8'd0;
      for (int k = 1; k <= 3; k++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         pulses = int'(gen_done);
         for (int t = 0; t < 12; t++) begin tick(); pulses += int'(gen_done); end
         m_grid = life(m_grid, ROWS, COLS); m_gen++; m_sr = ~m_sr;
         n_checks++;
         if (pulses != 1 || grid !== m_grid || gen_count !== 16'(m_gen)) begin
            n_fail++;
            $display("FAIL run0_tick%0d: done_cycles=%0d grid_ok=%b gc=%0d, need 1/1/%0d",
                     k, pulses, grid === m_grid, gen_count, m_gen);
         end
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      pulses = 0;
      for (int t = 0; t < 10; t++) begin tick(); pulses += int'(gen_done); end
      n_checks++;
      if (pulses != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL run_step_ignored: done_cycles=%0d busy=%b, need 0/0", pulses, busy);
      end
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick(); tick();
      run = 1'b0;
      pulses = 0;
      for (int t = 0; t < 15; t++) begin tick(); pulses += int'(gen_done); end
      m_still = (life(m_grid, ROWS, COLS) == m_grid);
      m_grid = life(m_grid, ROWS, COLS); m_gen++; m_sr = ~m_sr;
      n_checks++;
      if (pulses != 1 || grid !== m_grid || stateready !== m_sr) begin
         n_fail++;
         $display("FAIL run_drop_midgen: done_cycles=%0d grid_ok=%b sr=%b, need 1/1/%b",
                  pulses, grid === m_grid, stateready, m_sr);
      end
   endtask

   task automatic test_load_conflict();
      logic [N-1:0] g1, g2;
      int pulses, waited;
      bit ok, bad;
      g1 = rand_grid();
      g2 = rand_grid();
      load_grid = g1; load_valid = 1'b1; step = 1'b1;
      tick();
      load_valid = 1'b0; step = 1'b0;
      pulses = 0;
      for (int t = 0; t < 10; t++) begin tick(); pulses += int'(gen_done); end
      n_checks++;
      if (pulses != 0 || grid !== g1 || gen_count !== 16'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL load_step_same: done_cycles=%0d grid_ok=%b gc=%0d busy=%b, need 0/1/0/0",
                  pulses, grid === g1, gen_count, busy);
      end
      m_grid = g1; m_gen = 0;
      step = 1'b1;
      tick();
      step = 1'b0;
      m_sr = ~m_sr;
      load_grid = g2; load_valid = 1'b1;
      ok = 1'b0; bad = 1'b0; waited = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (load_ready) ok = 1'b1;
         else begin waited++; if (busy !== 1'b1) bad = 1'b1; end
         tick();
      end
      load_valid = 1'b0;
      n_checks++;
      if (!ok || bad || waited < 3 || grid !== g2 || gen_count !== 16'd0 || stateready !== m_sr) begin
         n_fail++;
         $display("FAIL load_busy: accepted=%b idle_while_blocked=%b waited=%0d grid_ok=%b gc=%0d, need 1/0/>=3/1/0",
                  ok, bad, waited, grid === g2, gen_count);
      end
      m_grid = g2; m_gen = 0; m_still = 1'b0;
   endtask

   task automatic test_glider();
      bit ok;
      do_load(glider_at(46, 78), ok);
      for (int k = 0; k < 4; k++) begin
         do_step(ok);
         n_checks++;
         if (!ok || grid !== m_grid) begin
            n_fail++;
            $display("FAIL glider_step%0d: done=%b grid_ok=%b, need 1/1", k + 1, ok, grid === m_grid);
         end
      end
      n_checks++;
      if (grid !== glider_at(47, 79) || gen_count !== 16'd4) begin
         n_fail++;
         $display("FAIL glider_wrap: shifted=%b gc=%0d, need 1/4", grid === glider_at(47, 79), gen_count);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      bit ok;
      do_load(glider_at(20, 20), ok);
      step = 1'b1;
      tick();
      step = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_sr = 1'b0;
      n_checks++;
      if (grid !== '0 || stateready !== 1'b0 || busy !== 1'b0 || gen_done !== 1'b0 || gen_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid: grid_nz=%b sr=%b busy=%b done=%b gc=%0d, need all 0",
                  |grid, stateready, busy, gen_done, gen_count);
      end
      pulses = 0;
      for (int t = 0; t < 8; t++) begin tick(); pulses += int'(gen_done); end
      n_checks++;
      if (pulses != 0 || grid !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: done_cycles=%0d grid_nz=%b, need 0/0", pulses, |grid);
      end
      do_load(glider_at(20, 20), ok);
      do_step(ok);
      n_checks++;
      if (!ok || grid !== m_grid || gen_count !== 16'd1 || stateready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_recover: done=%b grid_ok=%b gc=%0d sr=%b, need 1/1/1/1",
                  ok, grid === m_grid, gen_count, stateready);
      end
   endtask

   task automatic test_random();
      int nsteps;
      bit ok;
      for (int it = 0; it < 6; it++) begin
         do_load(rand_grid(), ok);
         nsteps = $urandom_range(1, 4);
         for (int k = 0; k < nsteps; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            step = 1'b1;
            tick();
            for (int t = 0; t < 3; t++) begin step = 1'($urandom % 2); tick(); end
            step = 1'b0;
            wait_done(20, ok);
            m_still = (life(m_grid, ROWS, COLS) == m_grid);
            m_grid = life(m_grid, ROWS, COLS); m_gen++; m_sr = ~m_sr;
            n_checks++;
            if (!ok || grid !== m_grid || gen_count !== 16'(m_gen) || still !== m_still || stateready !== m_sr) begin
               n_fail++;
               $display("FAIL random_it%0d_step%0d: done=%b grid_ok=%b gc=%0d still=%b sr=%b, need 1/1/%0d/%b/%b",
                        it, k, ok, grid === m_grid, gen_count, still, stateready, m_gen, m_still, m_sr);
            end
         end
         tick(); tick();
         n_checks++;
         if (busy !== 1'b0 || gen_count !== 16'(m_gen)) begin
            n_fail++;
            $display("FAIL random_it%0d_settled: busy=%b gc=%0d, need 0/%0d", it, busy, gen_count, m_gen);
         end
      end
   endtask

   task automatic test_small_wrap();
      logic [SN-1:0] sm;
      logic [N-1:0]  tmp;
      int early;
      bit ok;
      sm = 16'($urandom);
      s_load_grid = sm; s_load_valid = 1'b1;
      tick();
      s_load_valid = 1'b0;
      n_checks++;
      if (s_grid !== sm || s_gen_count !== 3'd0) begin
         n_fail++;
         $display("FAIL small_load: grid=%h gc=%0d, need %h/0", s_grid, s_gen_count, sm);
      end
      for (int k = 1; k <= 8; k++) begin
         s_step = 1'b1;
         tick();
         s_step = 1'b0;
         early = 0;
         tick(); early += int'(s_gen_done);
         tick(); early += int'(s_gen_done);
         tick();
         ok = s_gen_done;
         tmp = life({{(N-SN){1'b0}}, sm}, SR, SC);
         sm = tmp[SN-1:0];
         n_checks++;
         if (early != 0 || !ok || s_grid !== sm || s_gen_count !== 3'(k % 8)) begin
            n_fail++;
            $display("FAIL small_step%0d: early=%0d done@4=%b grid=%h gc=%0d, need 0/1/%h/%0d",
                     k, early, ok, s_grid, s_gen_count, sm, k % 8);
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b0; run = 1'b0; step = 1'b0; frame_tick = 1'b0; load_valid = 1'b0;
      frames_per_gen = 8'd1; load_grid = '0;
      s_reset = 1'b0; s_step = 1'b0; s_load_valid = 1'b0; s_load_grid = '0;
      test_reset();
      test_blinker();
      test_block();
      test_run();
      test_load_conflict();
      test_glider();
      test_reset_mid();
      test_random();
      test_small_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
